// File: rtl/distram_rw_arbiter.sv
// Round-robin read/write port arbiter in front of a 1R1W distributed RAM, with a post-reset init sweep.
// Optional define DISTRAM_ARB_WR_BYPASS_EN forwards same-cycle write data to a colliding read response.
module distram_rw_arbiter #(
  parameter int                     OUTER_WIDTH = 32,
  parameter int                     INNER_WIDTH = 32,
  parameter int                     N_RREQ      = 4,
  parameter int                     N_WREQ      = 2,
  parameter logic [INNER_WIDTH-1:0] INIT_VALUE  = '0,
  localparam int                    IDX_W       = $clog2(OUTER_WIDTH),
  localparam int                    RID_W       = (N_RREQ > 1) ? $clog2(N_RREQ) : 1
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [N_RREQ-1:0]               rreq_valid,
  input  logic [N_RREQ*IDX_W-1:0]         rreq_index,
  output logic [N_RREQ-1:0]               rreq_ready,
  output logic                            rresp_valid,
  output logic [RID_W-1:0]                rresp_id,
  output logic [INNER_WIDTH-1:0]          rresp_data,
  input  logic [N_WREQ-1:0]               wreq_valid,
  input  logic [N_WREQ*IDX_W-1:0]         wreq_index,
  input  logic [N_WREQ*INNER_WIDTH-1:0]   wreq_data,
  output logic [N_WREQ-1:0]               wreq_ready,
  output logic [IDX_W-1:0]                rindex,
  input  logic [INNER_WIDTH-1:0]          rdata,
  output logic                            wen,
  output logic [IDX_W-1:0]                windex,
  output logic [INNER_WIDTH-1:0]          wdata,
  output logic                            init_done
);

  localparam int WID_W = (N_WREQ > 1) ? $clog2(N_WREQ) : 1;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [IDX_W-1:0]       r_init_cnt;
  logic [RID_W-1:0]       r_rptr;
  logic [WID_W-1:0]       r_wptr;

  logic                   w_rany;
  logic [RID_W-1:0]       w_rid;
  logic                   w_wany;
  logic [WID_W-1:0]       w_wid;
  logic                   w_rd_fire;
  logic                   w_wr_fire;
  logic [INNER_WIDTH-1:0] w_rresp_d;

  function automatic logic [RID_W-1:0] rslot(input logic [RID_W-1:0] ptr, input int off);
    int s;
    s = (int'(ptr) + off) % N_RREQ;
    return s[RID_W-1:0];
  endfunction

  function automatic logic [WID_W-1:0] wslot(input logic [WID_W-1:0] ptr, input int off);
    int s;
    s = (int'(ptr) + off) % N_WREQ;
    return s[WID_W-1:0];
  endfunction

  // Search starts at the pointer and wraps; first valid requester wins.
  always_comb begin
    w_rany = 1'b0;
    w_rid  = '0;
    for (int off = 0; off < N_RREQ; off++) begin
      if (!w_rany && rreq_valid[rslot(r_rptr, off)]) begin
        w_rany = 1'b1;
        w_rid  = rslot(r_rptr, off);
      end
    end
  end

  always_comb begin
    w_wany = 1'b0;
    w_wid  = '0;
    for (int off = 0; off < N_WREQ; off++) begin
      if (!w_wany && wreq_valid[wslot(r_wptr, off)]) begin
        w_wany = 1'b1;
        w_wid  = wslot(r_wptr, off);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    rreq_ready  = '0;
    wreq_ready  = '0;
    rindex      = '0;
    wen         = 1'b0;
    windex      = '0;
    wdata       = '0;
    w_rd_fire   = 1'b0;
    w_wr_fire   = 1'b0;
    if (!RST) begin
      case (r_state)
        S_INIT: begin
          wen    = 1'b1;
          windex = r_init_cnt;
          wdata  = INIT_VALUE;
          if (r_init_cnt == IDX_W'(OUTER_WIDTH - 1)) w_state_nxt = S_RUN;
        end
        S_RUN: begin
          if (w_rany) begin
            rreq_ready[w_rid] = 1'b1;
            rindex            = rreq_index[w_rid*IDX_W +: IDX_W];
            w_rd_fire         = 1'b1;
          end
          if (w_wany) begin
            wreq_ready[w_wid] = 1'b1;
            wen               = 1'b1;
            windex            = wreq_index[w_wid*IDX_W +: IDX_W];
            wdata             = wreq_data[w_wid*INNER_WIDTH +: INNER_WIDTH];
            w_wr_fire         = 1'b1;
          end
        end
        default: w_state_nxt = S_INIT;
      endcase
    end
  end

`ifdef DISTRAM_ARB_WR_BYPASS_EN
  assign w_rresp_d = (w_wr_fire && (windex == rindex)) ? wdata : rdata;
`else
  assign w_rresp_d = rdata;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_INIT;
      r_init_cnt  <= '0;
      r_rptr      <= '0;
      r_wptr      <= '0;
      rresp_valid <= 1'b0;
      rresp_id    <= '0;
      rresp_data  <= '0;
      init_done   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      init_done   <= (w_state_nxt == S_RUN);
      rresp_valid <= w_rd_fire;
      if (r_state == S_INIT) r_init_cnt <= r_init_cnt + 1'b1;
      if (w_rd_fire) begin
        rresp_id   <= w_rid;
        rresp_data <= w_rresp_d;
        r_rptr     <= (w_rid == RID_W'(N_RREQ - 1)) ? '0 : w_rid + 1'b1;
      end
      if (w_wr_fire) r_wptr <= (w_wid == WID_W'(N_WREQ - 1)) ? '0 : w_wid + 1'b1;
    end
  end

endmodule

// File: doc/distram_rw_arbiter.md
Name: distram_rw_arbiter

Overview:
- Controller in front of a single distram_1rport_1wport instance (1 async read port, 1 write port).
- Shares the read port among N_RREQ requesters and the write port among N_WREQ requesters, each with independent round-robin arbitration.
- After reset, runs an init sweep that writes INIT_VALUE to every entry before any requester is served.
- Read responses are registered and returned one cycle after the grant, tagged with the requester id.

Parameters:
- OUTER_WIDTH, 32, number of distram entries (power of 2, >=2); IDX_W = $clog2(OUTER_WIDTH)
- INNER_WIDTH, 32, data width per entry
- N_RREQ, 4, read requesters (>=1); RID_W = max(1, $clog2(N_RREQ))
- N_WREQ, 2, write requesters (>=1)
- INIT_VALUE, '0, INNER_WIDTH value written to every entry during the init sweep

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- rreq_valid  in  N_RREQ  per-requester read request
- rreq_index  in  N_RREQ*IDX_W  packed read indices, requester i at [i*IDX_W +: IDX_W]
- rreq_ready  out  N_RREQ  one-hot read grant
- rresp_valid  out  1  read response valid
- rresp_id  out  RID_W  requester id of the response
- rresp_data  out  INNER_WIDTH  read data
- wreq_valid  in  N_WREQ  per-requester write request
- wreq_index  in  N_WREQ*IDX_W  packed write indices
- wreq_data  in  N_WREQ*INNER_WIDTH  packed write data
- wreq_ready  out  N_WREQ  one-hot write grant
- rindex  out  IDX_W  to distram read index
- rdata  in  INNER_WIDTH  from distram, combinational read of rindex
- wen  out  1  to distram write enable
- windex  out  IDX_W  to distram write index
- wdata  out  INNER_WIDTH  to distram write data
- init_done  out  1  high once the init sweep completes

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high: CLK, RST.
- Reset values (all registers, evaluated at the CLK edge with RST=1):
  - state=INIT, init_cnt=0, rptr=0, wptr=0
  - rresp_valid=0, rresp_id=0, rresp_data=0, init_done=0
  - While RST=1: wen=0, rreq_ready=0, wreq_ready=0.
- FSM state INIT (entered from reset):
  - Each cycle: wen=1, windex=init_cnt, wdata=INIT_VALUE; all ready outputs 0; rindex=0.
  - init_cnt increments each cycle.
  - At init_cnt==OUTER_WIDTH-1, transition to RUN. The sweep takes exactly OUTER_WIDTH cycles.
- FSM state RUN: init_done=1. Stays in RUN until RST.
- Read arbitration (RUN, combinational):
  - Grant the first i with rreq_valid[i], searching from rptr upward with wrap.
  - rreq_ready = one-hot grant, 0 if no valid. The handshake completes in the same cycle.
  - ready never asserts without the matching valid; it is not required to hold across cycles.
  - rindex = granted requester's index; 0 if no grant.
  - On a grant to k: rptr <= (k+1) mod N_RREQ. With no grant, rptr holds.
- Read response:
  - rresp_valid <= (read grant); rresp_id <= k; rresp_data <= rdata.
  - Latency: grant in cycle t -> response in cycle t+1 for exactly one cycle. No backpressure.
  - On cycles without a grant, rresp_id and rresp_data hold their previous values.
- Write arbitration: same scheme with wptr and wreq_*.
  - wen=1 on grant; windex/wdata come from the granted slot.
  - The write commits at the grant edge.
- Simultaneous read and write in one cycle: both ports are granted independently in the same cycle.
  - Same index, feature off: rresp_data is the pre-write value.
- Single requester (N=1): pointer stays 0; grant = valid.
- RST during RUN or INIT: the next cycle is INIT with init_cnt=0, pointers 0, and rresp_valid=0. Any in-flight response is dropped. The full sweep reruns.

Optional Feature:
- Macro: DISTRAM_ARB_WR_BYPASS_EN
- Defined: when a read grant and a write grant in the same cycle target the same index, rresp_data <= the granted wdata (write-to-read bypass). Different indices behave as without the macro.
- Undefined: rresp_data <= rdata always (read-before-write).

Test Plan:
- Init sweep, OUTER_WIDTH=32: release RST.
  - wen=1 for 32 cycles with windex 0..31 and wdata=INIT_VALUE.
  - Ready outputs are 0 throughout; init_done=1 on cycle 33.
  - A read of index 17 then returns INIT_VALUE.
- Round-robin read: all 4 rreq_valid held high, distinct indices.
  - Grants go 0,1,2,3,0 on consecutive cycles.
  - rresp_id follows one cycle later with the matching data.
  - Dropping requester 1 gives the sequence 0,2,3,0.
- Write then read: write 0xDEADBEEF to index 5 (requester 1) in cycle t; read index 5 in cycle t+1.
  - rresp_valid=1 at t+2 with 0xDEADBEEF and the reader's id.
- Same-cycle read/write: index 9 holds 0x11; in one cycle write 0x22 to index 9 and read index 9.
  - Macro off: response 0x11. Macro on: response 0x22.
  - A following read of index 9 returns 0x22 in both builds.
- Reset mid-run: assert RST for 1 cycle in the same cycle as a read grant.
  - rresp_valid=0 the next cycle; init_done=0.
  - A 32-cycle sweep reruns; rptr restarts at 0, so the first grant goes to requester 0.
